ft2232h_rx: RTL and testbench
=============================

// Module: ft2232h_rx
// PURPOSE
//  Receive side of the FT2232H 245 synchronous FIFO interface, clocked by the FT2232H 60 MHz CLKOUT.
//  Watches RXF#, drives OE# then RD#, and captures host bytes into an internal show-ahead FIFO.
//  Downstream FPGA logic drains the FIFO with a valid/ready handshake.
//  Sits alongside the FT2232H transmit block on the shared 8-bit ADBUS.
// PARAMETERS
//  DEPTH     16  internal FIFO entries; power of 2, >= 8
//  HEADROOM   4  minimum free entries required to start or continue a burst
//  CNT_W     16  width of rx_count
// PORTS
//  clk         in   1      FT2232H CLKOUT; the only clock
//  reset       in   1      synchronous, active-high reset
//  rxf         in   1      RXF#, active low; 0 = FT2232H has data for the FPGA
//  data_in     in   8      ADBUS read data from the FT2232H
//  oe          out  1      OE#, active low; 0 = FT2232H drives ADBUS
//  rd          out  1      RD#, active low; 0 = FPGA takes a byte on each rising edge
//  data_out    out  8      head of the FIFO (show-ahead)
//  data_valid  out  1      FIFO not empty
//  data_ready  in   1      downstream accepts data_out when data_valid && data_ready
//  rx_count    out  CNT_W  bytes captured since reset; wraps modulo 2^CNT_W
//  overflow    out  1      sticky; byte dropped because the FIFO was full
// BEHAVIOUR
//  Reset (clk edge with reset=1): state=IDLE, oe=1, rd=1, FIFO empty, data_valid=0,
//   data_out=0, rx_count=0, overflow=0. Reset mid-burst releases OE#/RD# at that edge.
//   All FIFO contents are discarded.
//  oe and rd are registered; no combinational path from rxf to oe or rd.
//  free = DEPTH - count, evaluated on the current count before this edge's push/pop.
//  States:
//   IDLE:    rxf==0 && free>=HEADROOM -> oe<=0, go OE_WAIT; otherwise stay, oe=rd=1.
//   OE_WAIT: rxf==1 -> oe<=1, go IDLE; else rd<=0, go READ.
//            Exactly one cycle of oe=0 precedes rd=0 (bus turnaround).
//   READ:    rxf==1 -> rd<=1, oe<=1, go IDLE.
//            free<HEADROOM -> rd<=1, oe<=1, go IDLE (back-off).
//            Otherwise stay, rd stays 0.
//  Capture rule: a byte is transferred at every rising edge where the registered rd==0 and the sampled
//   rxf==0; data_in is pushed and rx_count increments. Capture is independent of state, so the
//   edge that deasserts rd still captures if rxf==0.
//  HEADROOM covers bytes in flight while rd deassertion takes effect; it must be >= 2.
//  Push while full: accepted if a pop occurs on the same edge; otherwise the byte is dropped,
//   overflow<=1 (sticky until reset), and rx_count still increments.
//  Pop: data_valid && data_ready at the edge. Simultaneous push and pop leaves count unchanged.
//  Latency: a byte captured at edge N is visible on data_out, with data_valid=1, after edge N when
//   the FIFO was empty. Byte order is preserved.
//  FIFO pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.
// TESTING
//  1 Reset, then rxf=0 with bytes 0x10..0x17 and ready=1 -> oe low at cycle 1, rd low at cycle 2,
//    data_out 0x10..0x17 in order, rx_count=8.
//  2 rxf rises mid-burst after byte 0x03 -> rd=1 and oe=1 the next edge, no extra byte captured,
//    return to IDLE, burst resumes when rxf falls.
//  3 ready=0, rxf held 0, DEPTH=16 -> rd deasserts once free<4, count stays <=16, overflow=0,
//    reads resume after draining.
//  4 Force a push into a full FIFO with no pop -> byte dropped, overflow=1 until reset,
//    rx_count still increments.
//  5 Assert reset during READ -> oe=rd=1, data_valid=0, rx_count=0 the next cycle.
//  6 rxf pulses low for one cycle only -> oe low one cycle, rd never low, no capture, back to IDLE.

Source files
------------

// File: rtl/ft2232h_rx.sv
// ft2232h_rx
//   Receive side of the FT2232H 245 synchronous FIFO interface. Runs on the FT2232H CLKOUT.
//   Watches RXF#, drives OE# and then RD#, and captures host bytes into a show-ahead FIFO.
//   Downstream logic drains the FIFO with a valid/ready handshake.
//
// Ports
//   clk         FT2232H CLKOUT, the only clock
//   reset       synchronous, active-high reset
//   rxf         RXF#, active low: FT2232H has data for us
//   data_in     ADBUS read data
//   oe          OE#, active low, registered
//   rd          RD#, active low, registered
//   data_out    head of the FIFO (0 while empty)
//   data_valid  FIFO not empty
//   data_ready  downstream accepts data_out when data_valid is also high
//   rx_count    bytes captured since reset, wraps
//   overflow    sticky: a captured byte was dropped because the FIFO was full
module ft2232h_rx #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned HEADROOM = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rxf,
   input  logic [7:0]       data_in,
   output logic             oe,
   output logic             rd,
   output logic [7:0]       data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic [CNT_W-1:0] rx_count,
   output logic             overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] HEAD_C  = (AW+1)'(HEADROOM);

   typedef enum logic [1:0] {StIdle, StOeWait, StRead} state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   free;
   logic          capture;
   logic          pop;
   logic          full;
   logic          push_ok;

   // free is based on the occupancy before this edge's push/pop
   assign free       = DEPTH_C - count;
   assign full       = (count == DEPTH_C);
   assign data_valid = (count != '0);
   assign pop        = data_valid && data_ready;
   // A byte moves on every edge where our registered RD# and the sampled RXF# are both low,
   // regardless of FSM state; this covers the edge that releases RD#.
   assign capture    = !rd && !rxf;
   // A push into a full FIFO survives only if the head leaves on the same edge
   assign push_ok    = capture && (!full || pop);
   assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;

   // Bus-control FSM; oe and rd are registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= StIdle;
         oe    <= 1'b1;
         rd    <= 1'b1;
      end else begin
         case (state)
            StIdle: begin
               rd <= 1'b1;
               if (!rxf && free >= HEAD_C) begin
                  oe    <= 1'b0;
                  state <= StOeWait;
               end else begin
                  oe <= 1'b1;
               end
            end
            // One cycle of OE# low lets the FT2232H take the bus before RD# falls
            StOeWait: begin
               if (rxf) begin
                  oe    <= 1'b1;
                  state <= StIdle;
               end else begin
                  rd    <= 1'b0;
                  state <= StRead;
               end
            end
            // Back off early so bytes still in flight fit in the remaining headroom
            StRead: begin
               if (rxf || free < HEAD_C) begin
                  rd    <= 1'b1;
                  oe    <= 1'b1;
                  state <= StIdle;
               end
            end
            default: begin
               oe    <= 1'b1;
               rd    <= 1'b1;
               state <= StIdle;
            end
         endcase
      end
   end

   // FIFO storage, no reset needed: contents are masked by count
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // FIFO pointers, occupancy and status
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rx_count <= '0;
         overflow <= 1'b0;
      end else begin
         if (capture) begin
            rx_count <= rx_count + CNT_W'(1);
         end
         if (capture && !push_ok) begin
            overflow <= 1'b1;
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_ft2232h_rx.sv
// Testbench for ft2232h_rx: a host FIFO model drives RXF#/ADBUS, a reference queue tracks the
// bytes that should be held, and a monitor compares outputs against it on every falling edge.
module tb_ft2232h_rx;

   localparam int unsigned DEPTH    = 16;
   localparam int unsigned HEADROOM = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rxf = 1'b1;
   logic [7:0]  din = 8'h00;
   logic        oe, rd;
   logic [7:0]  dout;
   logic        dv;
   logic        ready = 1'b1;
   logic [15:0] rx_count;
   logic        ovf;

   // Second instance with minimal headroom, used only to reach the overflow path
   logic        reset2 = 1'b1;
   logic        rxf2 = 1'b1;
   logic [7:0]  din2 = 8'hA5;
   logic        oe2, rd2;
   logic [7:0]  dout2;
   logic        dv2;
   logic        ready2 = 1'b0;
   logic [15:0] rx_count2;
   logic        ovf2;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   ft2232h_rx #(.DEPTH(DEPTH), .HEADROOM(HEADROOM), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .rxf        (rxf),
      .data_in    (din),
      .oe         (oe),
      .rd         (rd),
      .data_out   (dout),
      .data_valid (dv),
      .data_ready (ready),
      .rx_count   (rx_count),
      .overflow   (ovf)
   );

   ft2232h_rx #(.DEPTH(8), .HEADROOM(1), .CNT_W(16)) dut2 (
      .clk        (clk),
      .reset      (reset2),
      .rxf        (rxf2),
      .data_in    (din2),
      .oe         (oe2),
      .rd         (rd2),
      .data_out   (dout2),
      .data_valid (dv2),
      .data_ready (ready2),
      .rx_count   (rx_count2),
      .overflow   (ovf2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + monitor ----------------
   logic [7:0]  model_q[$];
   int unsigned exp_cnt = 0;
   logic        exp_ovf = 1'b0;
   logic        armed = 1'b0;
   logic        prev_rd = 1'b1, prev_oe = 1'b1, prev2_oe = 1'b1, prev_rxf = 1'b1;
   logic        prev_reset = 1'b1;
   logic        cap, popm;

   always @(negedge clk) begin
      if (armed) begin
         // Outputs after the last rising edge vs. the model state after that edge
         check("data_valid", 32'(dv), 32'(model_q.size() != 0));
         check("rx_count", 32'(rx_count), exp_cnt % 65536);
         check("overflow", 32'(ovf), 32'(exp_ovf));
         if (model_q.size() != 0) check("data_out", 32'(dout), 32'(model_q[0]));
         if (prev_reset) begin
            check("reset_oe_rd", 32'({oe, rd}), 32'b11);
         end else begin
            if (!prev_rd && prev_rxf) check("rd_release", 32'({oe, rd}), 32'b11);
            if (!rd && prev_rd) check("turnaround", 32'({prev2_oe, prev_oe}), 32'b10);
         end
         if (!rd) check("rd_needs_oe", 32'(oe), 32'(0));
         check("occupancy_bound", 32'(model_q.size() <= DEPTH - HEADROOM + 2), 32'(1));
      end
      cap  = !rd && !rxf;
      popm = dv && ready;
      if (reset) begin
         armed = 1'b1;
         model_q.delete();
         exp_cnt = 0;
         exp_ovf = 1'b0;
      end else if (armed) begin
         if (popm && model_q.size() != 0) void'(model_q.pop_front());
         if (cap) begin
            exp_cnt++;
            if (model_q.size() < DEPTH) model_q.push_back(din);
            else exp_ovf = 1'b1;
         end
      end
      prev2_oe   = prev_oe;
      prev_oe    = oe;
      prev_rd    = rd;
      prev_rxf   = rxf;
      prev_reset = reset;
   end

   // ---------------- host FIFO stimulus ----------------
   logic [7:0] host_q[$];
   logic       host_hold = 1'b1;

   task automatic drive_host();
      rxf = (host_q.size() == 0) || host_hold;
      din = (host_q.size() != 0) ? host_q[0] : 8'($urandom);
   endtask

   task automatic tick();
      logic took;
      took = !rd && !rxf;
      @(posedge clk);
      #1;
      if (took && host_q.size() != 0) void'(host_q.pop_front());
      drive_host();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int caps2;
      logic found;

      // Test 1: reset, then a burst of 0x10..0x17
      ready = 1'b1;
      ticks(2);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) host_q.push_back(8'(8'h10 + i));
      host_hold = 1'b0;
      drive_host();
      tick();
      check("t1_oe_cycle1", 32'({oe, rd}), 32'b01);
      tick();
      check("t1_rd_cycle2", 32'({oe, rd}), 32'b00);
      ticks(20);
      check("t1_rx_count", 32'(rx_count), 32'd8);

      // Test 2: rxf rises right after byte 0x03
      for (int i = 0; i < 16; i++) host_q.push_back(8'(i));
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (host_q.size() != 0 && host_q[0] == 8'h04) found = 1'b1;
      end
      check("t2_reach_byte3", 32'(found), 32'(1));
      host_hold = 1'b1;
      drive_host();
      tick();
      check("t2_release", 32'({oe, rd}), 32'b11);
      ticks(3);
      check("t2_no_extra", 32'(rx_count), 32'd12);
      host_hold = 1'b0;
      drive_host();
      ticks(30);
      check("t2_resume", 32'(rx_count), 32'd24);

      // Test 3: downstream stalled, back-off by headroom, then drain
      ready = 1'b0;
      for (int i = 0; i < 30; i++) host_q.push_back(8'($urandom));
      drive_host();
      ticks(40);
      check("t3_backoff_count", 32'(rx_count), 32'd38);
      check("t3_rd_high", 32'(rd), 32'(1));
      check("t3_no_overflow", 32'(ovf), 32'(0));
      ready = 1'b1;
      ticks(80);
      check("t3_resume", 32'(rx_count), 32'd54);

      // Test 6: one-cycle RXF# pulse
      host_hold = 1'b1;
      for (int i = 0; i < 5; i++) host_q.push_back(8'($urandom));
      drive_host();
      ticks(3);
      host_hold = 1'b0;
      drive_host();
      tick();
      check("t6_oe_low", 32'({oe, rd}), 32'b01);
      host_hold = 1'b1;
      drive_host();
      tick();
      check("t6_back_idle", 32'({oe, rd}), 32'b11);
      ticks(3);
      check("t6_no_capture", 32'(rx_count), 32'd54);

      // Random traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         ready     = ($urandom_range(0, 3) != 0);
         host_hold = ($urandom_range(0, 4) == 0);
         if (host_q.size() < 20 && $urandom_range(0, 1) == 1) host_q.push_back(8'($urandom));
         drive_host();
         tick();
      end

      // Test 5: reset during READ
      host_hold = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 20; i++) host_q.push_back(8'($urandom));
      drive_host();
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (!rd) found = 1'b1;
      end
      check("t5_reach_read", 32'(found), 32'(1));
      ticks(2);
      reset = 1'b1;
      tick();
      check("t5_oe_rd", 32'({oe, rd}), 32'b11);
      check("t5_valid", 32'(dv), 32'(0));
      check("t5_count", 32'(rx_count), 32'(0));
      reset = 1'b0;
      host_hold = 1'b1;
      host_q.delete();
      drive_host();
      ticks(5);

      // Test 4: forced overflow on the minimal-headroom instance
      ticks(2);
      reset2 = 1'b0;
      rxf2 = 1'b0;
      caps2 = 0;
      for (int i = 0; i < 20; i++) begin
         if (!rd2 && !rxf2) caps2++;
         tick();
      end
      check("t4_captures", 32'(caps2), 32'd9);
      check("t4_rx_count", 32'(rx_count2), 32'd9);
      check("t4_overflow", 32'(ovf2), 32'(1));
      check("t4_valid", 32'(dv2), 32'(1));
      check("t4_head", 32'(dout2), 32'hA5);
      check("t4_bus_idle", 32'({oe2, rd2}), 32'b11);
      rxf2 = 1'b1;
      ready2 = 1'b1;
      ticks(12);
      check("t4_sticky", 32'(ovf2), 32'(1));
      check("t4_drained", 32'(dv2), 32'(0));
      reset2 = 1'b1;
      tick();
      check("t4_reset_ovf", 32'(ovf2), 32'(0));
      check("t4_reset_cnt", 32'(rx_count2), 32'(0));

      ticks(2);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
